// File: rtl/bias_relu_maxpool.sv
// Bias add with saturation, ReLU and 2x2/2 max pooling over a raster conv stream.
// Emits one pooled sample per window, two cycles after its bottom-right pixel.
module bias_relu_maxpool #(
   parameter int INT_WIDTH  = 8,
   parameter int FRAC_WIDTH = 8,
   parameter int MAX_WIDTH  = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [7:0]                      conv_width,
   input  logic [INT_WIDTH+FRAC_WIDTH-1:0] bias,
   input  logic [INT_WIDTH+FRAC_WIDTH-1:0] pixel_in,
   input  logic                            pixel_valid,
   output logic [INT_WIDTH+FRAC_WIDTH-1:0] pool_out,
   output logic                            pool_valid,
   output logic                            frame_done,
   output logic                            busy,
   output logic                            cfg_err
);

   localparam int DW    = INT_WIDTH + FRAC_WIDTH;
   localparam int DEPTH = MAX_WIDTH / 2;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0]    MAXW    = 9'(MAX_WIDTH);
   localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t          r_state, w_state_nxt;
   logic [7:0]      r_width, r_col, r_row;
   logic [DW-1:0]   r_bias;
   logic            r_sup, r_cfg_err;

   logic            r_s1_valid, r_s1_rodd, r_s1_last, r_s1_sup;
   logic [AW:0]     r_s1_col;
   logic [DW-1:0]   r_s1_val;

   logic [DW-1:0]   r_h, r_pool_out;
   logic            r_pool_valid, r_frame_done;
   logic [DW-1:0]   r_lb [DEPTH];

   logic            w_start, w_illegal, w_zero, w_sup;
   logic [7:0]      w_wcfg, w_width, w_col, w_row;
   logic            w_last_col, w_last;
   logic [DW-1:0]   w_bias, w_sat, w_relu, w_pair, w_pool;
   logic [DW:0]     w_sum;
   logic [AW-1:0]   w_idx;

   function automatic logic [DW-1:0] f_max(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   // The first pixel of a frame uses the live config, later ones the latched copy.
   assign w_start   = pixel_valid && (r_state == S_IDLE);
   assign w_wcfg    = {conv_width[7:1], 1'b0};
   assign w_zero    = (w_wcfg == 8'd0);
   assign w_illegal = conv_width[0] || (conv_width < 8'd2) ||
                      ({1'b0, conv_width} > MAXW);
   assign w_width   = w_start ? (w_zero ? 8'd2 : w_wcfg) : r_width;
   assign w_bias    = w_start ? bias : r_bias;
   assign w_sup     = w_start ? w_zero : r_sup;
   assign w_col     = w_start ? 8'd0 : r_col;
   assign w_row     = w_start ? 8'd0 : r_row;

   assign w_last_col = (w_col == w_width - 8'd1);
   assign w_last     = w_last_col && (w_row == w_width - 8'd1);

   assign w_sum = {pixel_in[DW-1], pixel_in} + {w_bias[DW-1], w_bias};

   always_comb begin
      w_sat = w_sum[DW-1:0];
      if (w_sum[DW] != w_sum[DW-1])
         w_sat = w_sum[DW] ? SAT_MIN : SAT_MAX;
      w_relu = w_sat[DW-1] ? '0 : w_sat;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (pixel_valid)
         w_state_nxt = w_last ? S_IDLE : S_ACTIVE;
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_width   <= 8'd2;
         r_bias    <= '0;
         r_sup     <= 1'b0;
         r_cfg_err <= 1'b0;
         r_col     <= '0;
         r_row     <= '0;
      end else if (pixel_valid) begin
         if (w_start) begin
            r_width <= w_width;
            r_bias  <= bias;
            r_sup   <= w_zero;
            if (w_illegal) r_cfg_err <= 1'b1;
         end
         r_col <= w_last_col ? 8'd0 : w_col + 8'd1;
         if (w_last_col)
            r_row <= (w_row == w_width - 8'd1) ? 8'd0 : w_row + 8'd1;
         else
            r_row <= w_row;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_val   <= '0;
         r_s1_col   <= '0;
         r_s1_rodd  <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_sup   <= 1'b0;
      end else begin
         r_s1_valid <= pixel_valid;
         if (pixel_valid) begin
            r_s1_val  <= w_relu;
            r_s1_col  <= w_col[AW:0];
            r_s1_rodd <= w_row[0];
            r_s1_last <= w_last;
            r_s1_sup  <= w_sup;
         end
      end
   end

   assign w_idx  = r_s1_col[AW:1];
   assign w_pair = f_max(r_h, r_s1_val);
   assign w_pool = f_max(w_pair, r_lb[w_idx]);

   always_ff @(posedge clk) begin
      if (r_s1_valid && !r_s1_rodd && r_s1_col[0])
         r_lb[w_idx] <= w_pair;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_h          <= '0;
         r_pool_out   <= '0;
         r_pool_valid <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_pool_valid <= 1'b0;
         r_frame_done <= 1'b0;
         if (r_s1_valid) begin
            case ({r_s1_rodd, r_s1_col[0]})
               2'b00, 2'b10: r_h <= r_s1_val;
               2'b11: begin
                  if (!r_s1_sup) begin
                     r_pool_out   <= w_pool;
                     r_pool_valid <= 1'b1;
                     r_frame_done <= r_s1_last;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign pool_out   = r_pool_out;
   assign pool_valid = r_pool_valid;
   assign frame_done = r_frame_done;
   assign busy       = (r_state == S_ACTIVE);
   assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_bias_relu_maxpool.sv
// Scoreboard bench: directed frames queue expected pooled words,
// a negedge monitor pops and checks value, frame_done and latency.
module tb_bias_relu_maxpool;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  conv_width = 8'd4;
   logic [15:0] bias = '0;
   logic [15:0] pixel_in = '0;
   logic        pixel_valid = 1'b0;
   logic [15:0] pool_out;
   logic        pool_valid, frame_done, busy, cfg_err;

   bias_relu_maxpool dut (
      .clk         (clk),
      .reset       (reset),
      .conv_width  (conv_width),
      .bias        (bias),
      .pixel_in    (pixel_in),
      .pixel_valid (pixel_valid),
      .pool_out    (pool_out),
      .pool_valid  (pool_valid),
      .frame_done  (frame_done),
      .busy        (busy),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] v;
      logic        fd;
      int          due;
   } exp_t;

   exp_t        q[$];
   exp_t        m_e;
   logic [15:0] g_pix[$];
   int          g_br[$];
   logic [15:0] g_exp[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;
   int          n_fd = 0;
   int          fd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (pool_valid) begin
         if (q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected pool_valid: got %h want none", pool_out);
         end else begin
            m_e = q.pop_front();
            chk("pool_out", {16'h0, pool_out}, {16'h0, m_e.v});
            chk("frame_done", {31'h0, frame_done}, {31'h0, m_e.fd});
            chk("latency", cyc, m_e.due);
         end
      end else if (frame_done) begin
         n_chk++;
         n_err++;
         $display("FAIL lone frame_done: got 1 want 0");
      end
      if (frame_done) n_fd++;
   end

   task automatic load_ramp(input int n);
      g_pix.delete();
      for (int i = 0; i < n; i++) g_pix.push_back(16'((i + 1) * 256));
   endtask

   task automatic load_const(input int n, input logic [15:0] v);
      g_pix.delete();
      for (int i = 0; i < n; i++) g_pix.push_back(v);
   endtask

   task automatic send_frame(input logic [7:0] w, input logic [15:0] b,
                             input bit gaps, input bit full);
      int   e;
      int   g;
      exp_t x;
      e = 0;
      for (int i = 0; i < g_pix.size(); i++) begin
         if (gaps && i > 0) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
               @(negedge clk);
               pixel_valid = 1'b0;
            end
         end
         @(negedge clk);
         if (i == 1) chk("busy_mid", {31'h0, busy}, 32'd1);
         conv_width  = w;
         bias        = b;
         pixel_valid = 1'b1;
         pixel_in    = g_pix[i];
         if (e < g_br.size() && g_br[e] == i) begin
            x.v   = g_exp[e];
            x.fd  = full && (e == g_br.size() - 1);
            x.due = cyc + 2;
            q.push_back(x);
            e++;
         end
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      @(negedge clk);
      pixel_valid = 1'b0;
      while (q.size() > 0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_chk++;
      if (q.size() > 0) begin
         n_err++;
         $display("FAIL drain: got %0d missing outputs want 0", q.size());
         q.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic exp_s1();
      load_ramp(16);
      g_br  = '{5, 7, 13, 15};
      g_exp = '{16'h0600, 16'h0800, 16'h0E00, 16'h1000};
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_pool_out", {16'h0, pool_out}, 32'h0);
      chk("rst_pool_valid", {31'h0, pool_valid}, 32'h0);
      chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_cfg_err", {31'h0, cfg_err}, 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      exp_s1();
      send_frame(8'd4, 16'h0000, 1'b0, 1'b1);
      drain();
      chk("busy_idle", {31'h0, busy}, 32'h0);

      exp_s1();
      g_exp = '{16'h0000, 16'h0200, 16'h0800, 16'h0A00};
      send_frame(8'd4, 16'hFA00, 1'b0, 1'b1);
      drain();

      load_const(4, 16'h7F00);
      g_br  = '{3};
      g_exp = '{16'h7FFF};
      send_frame(8'd2, 16'h0200, 1'b0, 1'b1);
      drain();

      load_const(4, 16'h8100);
      g_exp = '{16'h0000};
      send_frame(8'd2, 16'hFE00, 1'b0, 1'b1);
      drain();

      exp_s1();
      send_frame(8'd4, 16'h0000, 1'b1, 1'b1);
      drain();

      load_ramp(7);
      g_br  = '{5};
      g_exp = '{16'h0600};
      send_frame(8'd4, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      reset       = 1'b1;
      pixel_valid = 1'b1;
      pixel_in    = 16'h7000;
      @(negedge clk);
      chk("midrst_pool_out", {16'h0, pool_out}, 32'h0);
      chk("midrst_busy", {31'h0, busy}, 32'h0);
      reset       = 1'b0;
      pixel_valid = 1'b0;
      repeat (2) @(negedge clk);
      exp_s1();
      send_frame(8'd4, 16'h0000, 1'b0, 1'b1);
      drain();
      chk("cfg_err_clean", {31'h0, cfg_err}, 32'h0);

      exp_s1();
      send_frame(8'd5, 16'h0000, 1'b0, 1'b1);
      drain();
      chk("cfg_err_w5", {31'h0, cfg_err}, 32'h1);

      load_ramp(4);
      g_br.delete();
      g_exp.delete();
      send_frame(8'd1, 16'h0000, 1'b0, 1'b1);
      drain();
      chk("cfg_err_sticky", {31'h0, cfg_err}, 32'h1);
      chk("busy_after_w1", {31'h0, busy}, 32'h0);

      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("cfg_err_cleared", {31'h0, cfg_err}, 32'h0);

      fd0 = n_fd;
      exp_s1();
      send_frame(8'd4, 16'h0000, 1'b0, 1'b1);
      send_frame(8'd4, 16'h0000, 1'b0, 1'b1);
      drain();
      chk("fd_count", n_fd - fd0, 32'd2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
